reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Sits directly downstream of the watchdog timer and consumes its system-reset request. Converts a watchdog request, a software request or a power-on reset into a two-stage reset sequence: core reset (`sys_rst_o`) held for a programmable time, then peripheral reset (`periph_rst_o`) released a programmable number of cycles later. It exposes control, timing, reset-cause and event-count registers on the same 8-bit APB-style register port as the watchdog. Its own registers are cleared only by `prst_i`, so cause and count survive the resets it generates.

## Interface
- `HOLD_RST`, 16: reset value of the HOLD register.
- `STAGGER_RST`, 4: reset value of the STAGGER register.
- `pclk_i` input 1: single clock; all logic on the rising edge.
- `prst_i` input 1: reset, asynchronous, active-low.
- `paddr_i` input 8: register address.
- `pwdata_i` input 8: write data.
- `pwrite_i` input 1: 1 = write, 0 = read.
- `penable_i` input 1: access request.
- `prdata_o` output 8: read data, valid while `pready_o`=1.
- `pready_o` output 1: one-cycle access-complete strobe.
- `pslverr_o` output 1: error for an unmapped address, valid with `pready_o`.
- `wdt_rst_req_i` input 1: watchdog reset request (`systm_rst_o` of the watchdog); level, rising-edge triggered.
- `sys_rst_o` output 1: core reset, active-high.
- `periph_rst_o` output 1: peripheral reset, active-high.
- `seq_busy_o` output 1: high whenever the FSM is not IDLE.

## Operation
- Register map:
  - 0x00 CTRL: [0] SW_RST, write-1 triggers, reads 0. [1] WDT_EN, reset 1. Bits [7:2] read 0.
  - 0x01 HOLD: reset `HOLD_RST`.
  - 0x02 STAGGER: reset `STAGGER_RST`.
  - 0x03 CAUSE: [0] WDT, [1] SW, [2] POR; sticky; write-1-to-clear; reset 8'h04.
  - 0x04 COUNT: completed WDT/SW sequences; saturates at 255; any write clears it; reset 0.
- Unmapped address:
  - Completes with `pslverr_o`=1 and `prdata_o`=0.
  - Writes are ignored.
- Access handshake:
  - An access is accepted on an edge where `penable_i`=1 and `pready_o`=0.
  - After that edge, `pready_o`=1 for exactly one cycle, with `prdata_o` and `pslverr_o` valid.
  - A write commits on the accepting edge.
  - No new access is accepted while `pready_o`=1. The master must drop `penable_i` on the edge after `pready_o`.
- FSM states: IDLE, ASSERT, STAGGER.
  - IDLE -> ASSERT on a trigger: a `wdt_rst_req_i` rising edge with WDT_EN=1, or a pending SW_RST.
  - On entry to ASSERT, HOLD and STAGGER are latched. A HOLD value of 0 is treated as 1.
  - ASSERT: `sys_rst_o`=1 and `periph_rst_o`=1 for HOLD cycles, then go to STAGGER.
  - STAGGER: `sys_rst_o`=0 and `periph_rst_o`=1 for STAGGER cycles, then go to IDLE with both outputs 0.
  - STAGGER=0: both outputs release on the same edge.
  - On return to IDLE, COUNT increments unless the sequence was the power-on sequence.
- Edge detect: `wdt_rst_req_i` is registered; a rising edge is the current sample 1 with the previous sample 0. A request held high triggers only once.
- Cause capture:
  - A trigger in any state sets its CAUSE bit.
  - A trigger outside IDLE does not restart, extend or queue a sequence.
  - Simultaneous WDT and SW triggers in IDLE set both bits and start one sequence.
  - A W1C on the same edge as a set: the set wins.
- WDT_EN=0: watchdog edges are ignored entirely; no CAUSE bit is set.

## Timing
- Reset values:
  - `prdata_o`=0, `pready_o`=0, `pslverr_o`=0.
  - `sys_rst_o`=1, `periph_rst_o`=1, `seq_busy_o`=1.
  - FSM is in ASSERT running the power-on sequence with `HOLD_RST`/`STAGGER_RST`.
- Watchdog latency:
  - Edge k samples `wdt_rst_req_i`=1 (previous sample 0).
  - `sys_rst_o`, `periph_rst_o` and `seq_busy_o` are all 1 after edge k.
  - `sys_rst_o` falls after edge k+HOLD.
  - `periph_rst_o` and `seq_busy_o` fall after edge k+HOLD+STAGGER.
- Software latency: a SW_RST write committed at edge k behaves like a watchdog trigger sampled at edge k+1.
- COUNT updates on the same edge `periph_rst_o` falls.
- Writes to HOLD/STAGGER during a sequence take effect only on the next sequence.
- `prst_i` asserted mid-sequence: immediate asynchronous return to the reset values, then a fresh power-on sequence after release.

## Test plan
- Power-on reset:
  - Stimulus: release `prst_i`.
  - Required: `sys_rst_o` high for 16 cycles, `periph_rst_o` high for 20 cycles; CAUSE=0x04; COUNT=0.
- Watchdog trigger with HOLD=200, STAGGER=4:
  - Stimulus: pulse `wdt_rst_req_i`.
  - Required: `sys_rst_o` high for 200 cycles, `periph_rst_o` high for 204 cycles; CAUSE[0]=1; COUNT=1.
- Software trigger with HOLD=0, STAGGER=0:
  - Stimulus: write 0x03 to CTRL.
  - Required: both outputs high for exactly 1 cycle; CAUSE[1]=1.
- Retrigger:
  - Stimulus: a watchdog edge during ASSERT, then write 0x01 to CAUSE.
  - Required: sequence length unchanged; CAUSE[0] reads 1 before the write and 0 after.
- WDT_EN=0 and bad address:
  - Stimulus: watchdog edge with WDT_EN=0, then a read of 0x07.
  - Required: no sequence and no CAUSE change; the read returns `pslverr_o`=1 and `prdata_o`=0 with a single `pready_o` strobe.
- Reset mid-sequence:
  - Stimulus: assert `prst_i` during STAGGER.
  - Required: outputs return to their reset values immediately; after release, COUNT=0 and CAUSE=0x04.

Source files
------------

// File: rtl/reset_sequencer_if.sv
// Register-port bundle shared with the watchdog: 8-bit APB-style access
// with a one-cycle ready strobe and an error flag for unmapped addresses.
interface reset_sequencer_if;
    logic [7:0] paddr_i;
    logic [7:0] pwdata_i;
    logic       pwrite_i;
    logic       penable_i;
    logic [7:0] prdata_o;
    logic       pready_o;
    logic       pslverr_o;

    modport master (
        output paddr_i, pwdata_i, pwrite_i, penable_i,
        input  prdata_o, pready_o, pslverr_o
    );

    modport slave (
        input  paddr_i, pwdata_i, pwrite_i, penable_i,
        output prdata_o, pready_o, pslverr_o
    );
endinterface

// File: rtl/reset_sequencer.sv
// Two-stage reset sequencer: turns a watchdog edge, a software request or
// power-on into core reset for HOLD cycles followed by peripheral reset for
// a further STAGGER cycles. Its registers are cleared only by prst_i, so
// CAUSE and COUNT survive the resets it generates.
module reset_sequencer #(
    parameter logic [7:0] HOLD_RST    = 8'd16,
    parameter logic [7:0] STAGGER_RST = 8'd4
) (
    input  logic               pclk_i,
    input  logic               prst_i,
    reset_sequencer_if.slave   bus,
    input  logic               wdt_rst_req_i,
    output logic               sys_rst_o,
    output logic               periph_rst_o,
    output logic               seq_busy_o
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ASSERT  = 2'd1;
    localparam logic [1:0] ST_STAGGER = 2'd2;

    localparam logic [7:0] HOLD_RST_M1 = (HOLD_RST == 8'd0) ? 8'd0 : HOLD_RST - 8'd1;

    logic [1:0] state;
    logic [7:0] cnt;
    logic [7:0] stg_lat;
    logic       por_seq;

    logic [7:0] hold_reg;
    logic [7:0] stagger_reg;
    logic [7:0] count_reg;
    logic [2:0] cause;
    logic       wdt_en;
    logic       wdt_q;
    logic       sw_pend;

    logic       accept;
    logic       wr;
    logic       wdt_trig;
    logic       sw_trig;
    logic       trig;
    logic       seq_done;
    logic [7:0] rd_data;
    logic       addr_err;

    assign accept   = bus.penable_i & ~bus.pready_o;
    assign wr       = accept & bus.pwrite_i;
    assign wdt_trig = wdt_en & wdt_rst_req_i & ~wdt_q;
    assign sw_trig  = sw_pend;
    assign trig     = wdt_trig | sw_trig;

    // Last cycle of a sequence: ASSERT with no stagger, or end of STAGGER.
    assign seq_done = (cnt == 8'd0) &&
                      (((state == ST_ASSERT) && (stg_lat == 8'd0)) || (state == ST_STAGGER));

    assign sys_rst_o    = (state == ST_ASSERT);
    assign periph_rst_o = (state != ST_IDLE);
    assign seq_busy_o   = (state != ST_IDLE);

    // Register read mux and unmapped-address decode.
    always_comb begin
        rd_data  = '0;
        addr_err = 1'b0;
        case (bus.paddr_i)
            8'h00:   rd_data = {6'b0, wdt_en, 1'b0};
            8'h01:   rd_data = hold_reg;
            8'h02:   rd_data = stagger_reg;
            8'h03:   rd_data = {5'b0, cause};
            8'h04:   rd_data = count_reg;
            default: addr_err = 1'b1;
        endcase
    end

    // Sequence FSM; HOLD/STAGGER are latched on entry so mid-sequence writes wait.
    always_ff @(posedge pclk_i or negedge prst_i) begin
        if (!prst_i) begin
            state   <= ST_ASSERT;
            cnt     <= HOLD_RST_M1;
            stg_lat <= STAGGER_RST;
            por_seq <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (trig) begin
                        state   <= ST_ASSERT;
                        cnt     <= (hold_reg == 8'd0) ? 8'd0 : hold_reg - 8'd1;
                        stg_lat <= stagger_reg;
                    end
                end
                ST_ASSERT: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else if (stg_lat == 8'd0) begin
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_STAGGER;
                        cnt   <= stg_lat - 8'd1;
                    end
                end
                ST_STAGGER: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (seq_done) begin
                por_seq <= 1'b0;
            end
        end
    end

    // Control/timing registers, trigger sampling and sticky cause capture.
    always_ff @(posedge pclk_i or negedge prst_i) begin
        if (!prst_i) begin
            hold_reg    <= HOLD_RST;
            stagger_reg <= STAGGER_RST;
            wdt_en      <= 1'b1;
            cause       <= 3'b100;
            wdt_q       <= 1'b0;
            sw_pend     <= 1'b0;
        end else begin
            wdt_q   <= wdt_rst_req_i;
            sw_pend <= wr && (bus.paddr_i == 8'h00) && bus.pwdata_i[0];
            if (wr) begin
                case (bus.paddr_i)
                    8'h00:   wdt_en      <= bus.pwdata_i[1];
                    8'h01:   hold_reg    <= bus.pwdata_i;
                    8'h02:   stagger_reg <= bus.pwdata_i;
                    default: ;
                endcase
            end
            // New triggers are ORed in after the W1C mask so a same-edge set wins.
            cause <= (cause & ~((wr && (bus.paddr_i == 8'h03)) ? bus.pwdata_i[2:0] : 3'b000))
                     | {1'b0, sw_trig, wdt_trig};
        end
    end

    // Completed-sequence counter: saturating, cleared by any write.
    always_ff @(posedge pclk_i or negedge prst_i) begin
        if (!prst_i) begin
            count_reg <= '0;
        end else if (seq_done && !por_seq) begin
            if (count_reg != 8'hFF) begin
                count_reg <= count_reg + 8'd1;
            end
        end else if (wr && (bus.paddr_i == 8'h04)) begin
            count_reg <= '0;
        end
    end

    // Access completion: one-cycle ready strobe with data and error.
    always_ff @(posedge pclk_i or negedge prst_i) begin
        if (!prst_i) begin
            bus.pready_o  <= 1'b0;
            bus.prdata_o  <= '0;
            bus.pslverr_o <= 1'b0;
        end else if (accept) begin
            bus.pready_o  <= 1'b1;
            bus.prdata_o  <= bus.pwrite_i ? 8'h00 : rd_data;
            bus.pslverr_o <= addr_err;
        end else begin
            bus.pready_o  <= 1'b0;
            bus.prdata_o  <= '0;
            bus.pslverr_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: stimulus pushes expected bus
// responses and expected sequence lengths; monitors pop and compare.
module tb_reset_sequencer;

    typedef struct {
        logic [7:0] data;
        logic       err;
        bit         chk_data;
        int         addr;
    } bus_exp_t;

    typedef struct {
        int sys_len;
        int per_len;
    } seq_exp_t;

    logic pclk = 1'b0;
    logic prst = 1'b0;
    logic wdt  = 1'b0;
    logic sys_rst, periph_rst, seq_busy;

    int checks   = 0;
    int failures = 0;

    bus_exp_t bus_q[$];
    seq_exp_t seq_q[$];

    reset_sequencer_if bus();

    reset_sequencer #(.HOLD_RST(8'd16), .STAGGER_RST(8'd4)) dut (
        .pclk_i        (pclk),
        .prst_i        (prst),
        .bus           (bus),
        .wdt_rst_req_i (wdt),
        .sys_rst_o     (sys_rst),
        .periph_rst_o  (periph_rst),
        .seq_busy_o    (seq_busy)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Bus monitor: compare each ready strobe against the oldest expectation.
    logic pready_prev = 1'b0;
    always @(negedge pclk) begin
        bus_exp_t e;
        if (bus.pready_o) begin
            check("pready_single", int'(pready_prev), 0);
            if (bus_q.size() == 0) begin
                check("bus_unexpected_ready", 1, 0);
            end else begin
                e = bus_q.pop_front();
                check($sformatf("pslverr@%0h", e.addr), int'(bus.pslverr_o), int'(e.err));
                if (e.chk_data) begin
                    check($sformatf("prdata@%0h", e.addr), int'(bus.prdata_o), int'(e.data));
                end
            end
        end
        pready_prev = bus.pready_o;
    end

    // Sequence monitor: measure high time of each reset output per sequence.
    int sys_n = 0, per_n = 0, busy_n = 0;
    logic per_prev = 1'b0;
    always @(negedge pclk) begin
        seq_exp_t s;
        if (!prst) begin
            sys_n = 0; per_n = 0; busy_n = 0;
            per_prev = 1'b1;
        end else begin
            if (sys_rst)    sys_n++;
            if (periph_rst) per_n++;
            if (seq_busy)   busy_n++;
            if (per_prev && !periph_rst) begin
                if (seq_q.size() == 0) begin
                    check("seq_unexpected", 1, 0);
                end else begin
                    s = seq_q.pop_front();
                    check("sys_rst_len",    sys_n,  s.sys_len);
                    check("periph_rst_len", per_n,  s.per_len);
                    check("seq_busy_len",   busy_n, s.per_len);
                end
                sys_n = 0; per_n = 0; busy_n = 0;
            end
            per_prev = periph_rst;
        end
    end

    task automatic bus_xfer(input logic [7:0] addr, input logic is_wr, input logic [7:0] wdata,
                            input logic [7:0] exp_data, input logic exp_err, input bit chk);
        bus_exp_t e;
        int n;
        bit done;
        e.data = exp_data; e.err = exp_err; e.chk_data = chk; e.addr = int'(addr);
        bus_q.push_back(e);
        bus.paddr_i   = addr;
        bus.pwdata_i  = wdata;
        bus.pwrite_i  = is_wr;
        bus.penable_i = 1'b1;
        n = 0; done = 1'b0;
        while (!done && n < 8) begin
            tick();
            n++;
            if (bus.pready_o) done = 1'b1;
        end
        bus.penable_i = 1'b0;
        if (!done) check("bus_timeout", 0, 1);
        tick();
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] data);
        bus_xfer(addr, 1'b1, data, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [7:0] addr, input logic [7:0] exp);
        bus_xfer(addr, 1'b0, 8'h00, exp, 1'b0, 1'b1);
    endtask

    task automatic push_seq(input int s, input int p);
        seq_exp_t x;
        x.sys_len = s; x.per_len = p;
        seq_q.push_back(x);
    endtask

    task automatic wait_idle();
        int n;
        tick(); tick();
        n = 0;
        while (seq_busy && n < 2000) begin
            tick();
            n++;
        end
        if (seq_busy) check("idle_timeout", 1, 0);
    endtask

    task automatic pulse_wdt();
        wdt = 1'b1;
        tick();
        wdt = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sys"},     int'(sys_rst),        1);
        check({tag, "_periph"},  int'(periph_rst),     1);
        check({tag, "_busy"},    int'(seq_busy),       1);
        check({tag, "_pready"},  int'(bus.pready_o),   0);
        check({tag, "_prdata"},  int'(bus.prdata_o),   0);
        check({tag, "_pslverr"}, int'(bus.pslverr_o),  0);
    endtask

    initial begin
        bus.paddr_i   = 8'h00;
        bus.pwdata_i  = 8'h00;
        bus.pwrite_i  = 1'b0;
        bus.penable_i = 1'b0;

        // Power-on reset
        tick(); tick(); tick();
        check_reset_outputs("por");
        push_seq(16, 20);
        prst = 1'b1;
        wait_idle();
        rd(8'h03, 8'h04);
        rd(8'h04, 8'h00);
        rd(8'h00, 8'h02);
        rd(8'h01, 8'h10);
        rd(8'h02, 8'h04);

        // Watchdog trigger, HOLD=200 STAGGER=4
        wr(8'h01, 8'd200);
        wr(8'h02, 8'd4);
        wr(8'h03, 8'h07);
        rd(8'h03, 8'h00);
        push_seq(200, 204);
        pulse_wdt();
        wait_idle();
        rd(8'h03, 8'h01);
        rd(8'h04, 8'h01);

        // Software trigger, HOLD=0 STAGGER=0
        wr(8'h01, 8'd0);
        wr(8'h02, 8'd0);
        wr(8'h03, 8'h01);
        push_seq(1, 1);
        wr(8'h00, 8'h03);
        wait_idle();
        rd(8'h03, 8'h02);
        rd(8'h04, 8'h02);
        rd(8'h00, 8'h02);

        // Retrigger during ASSERT, then W1C of the watchdog cause bit
        wr(8'h01, 8'd20);
        wr(8'h02, 8'd3);
        wr(8'h03, 8'h07);
        push_seq(20, 23);
        pulse_wdt();
        tick(); tick(); tick();
        pulse_wdt();
        rd(8'h03, 8'h01);
        wr(8'h03, 8'h01);
        rd(8'h03, 8'h00);
        wait_idle();
        rd(8'h04, 8'h03);

        // Watchdog disabled, then unmapped address
        wr(8'h00, 8'h00);
        rd(8'h00, 8'h00);
        pulse_wdt();
        tick(); tick();
        check("wdt_dis_busy", int'(seq_busy), 0);
        for (int i = 0; i < 30; i++) tick();
        rd(8'h03, 8'h00);
        rd(8'h04, 8'h03);
        bus_xfer(8'h07, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
        bus_xfer(8'h07, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b0);
        wr(8'h00, 8'h02);

        // Reset asserted during STAGGER
        wr(8'h02, 8'd10);
        pulse_wdt();
        for (int i = 0; i < 22; i++) tick();
        check("mid_stagger_sys",    int'(sys_rst),    0);
        check("mid_stagger_periph", int'(periph_rst), 1);
        prst = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        tick(); tick();
        push_seq(16, 20);
        prst = 1'b1;
        wait_idle();
        rd(8'h04, 8'h00);
        rd(8'h03, 8'h04);
        rd(8'h01, 8'h10);
        rd(8'h02, 8'h04);
        rd(8'h00, 8'h02);

        tick(); tick(); tick();
        check("bus_q_left", bus_q.size(), 0);
        check("seq_q_left", seq_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
